// File: rtl/bsg_fsb_out_arbiter.sv
// bsg_fsb_out_arbiter
// Round-robin burst arbiter that shares one outbound comm-link channel among
// nodes_p node streams. The winning word is captured in a single registered
// output stage (v_o/data_o/grant_id_o) that is drained by ready_i.
//
// Output stage states:
//   state | meaning
//   EMPTY | output stage holds no word, v_o=0
//   FULL  | output stage holds a word from node grant_id_o, v_o=1
module bsg_fsb_out_arbiter #(
   parameter int width_p     = 80,
   parameter int nodes_p     = 4,
   parameter int burst_max_p = 4,
   localparam int lg_nodes_lp = (nodes_p > 1) ? $clog2(nodes_p) : 1,
   localparam int lg_burst_lp = $clog2(burst_max_p + 1)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [nodes_p-1:0]     node_en_i,
   input  logic [nodes_p-1:0]     node_v_i,
   input  logic [width_p-1:0]     node_data_i [nodes_p-1:0],
   output logic [nodes_p-1:0]     node_yumi_o,
   output logic                   v_o,
   output logic [width_p-1:0]     data_o,
   output logic [lg_nodes_lp-1:0] grant_id_o,
   input  logic                   ready_i
);

   localparam logic [lg_burst_lp-1:0] burst_max_lp = lg_burst_lp'(burst_max_p);
   localparam logic [lg_nodes_lp-1:0] last_rst_lp  = lg_nodes_lp'(nodes_p - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e                   r_state;
   state_e                   w_state_nxt;
   logic [width_p-1:0]       r_data;
   logic [lg_nodes_lp-1:0]   r_grant_id;
   logic [lg_nodes_lp-1:0]   r_last;
   logic [lg_burst_lp-1:0]   r_burst_cnt;

   logic [nodes_p-1:0]       w_req;
   logic                     w_space;
   logic                     w_others;
   logic                     w_keep;
   logic                     w_win_v;
   logic [lg_nodes_lp-1:0]   w_win_id;
   logic                     w_load;
   int                       w_idx;

   assign w_req   = node_v_i & node_en_i;
   assign w_space = (r_state == EMPTY) | ready_i;

   // any eligible requester other than the current burst owner
   always_comb begin
      w_others = 1'b0;
      for (int k = 0; k < nodes_p; k++) begin
         if (w_req[k] && (r_last != lg_nodes_lp'(k))) begin
            w_others = 1'b1;
         end
      end
   end

   // A zero burst count means nothing has been granted since reset, so there
   // is no burst to extend and node 0 wins through the round-robin search.
   assign w_keep = w_req[r_last] && (r_burst_cnt != '0) &&
                   ((r_burst_cnt < burst_max_lp) || !w_others);

   // winner selection: burst keep, else first requester after r_last (wrapping,
   // with r_last itself searched last)
   always_comb begin
      w_win_v  = 1'b0;
      w_win_id = '0;
      w_idx    = 0;
      if (w_keep) begin
         w_win_v  = 1'b1;
         w_win_id = r_last;
      end else begin
         for (int s = nodes_p; s >= 1; s--) begin
            w_idx = int'(r_last) + s;
            if (w_idx >= nodes_p) begin
               w_idx = w_idx - nodes_p;
            end
            if (w_req[lg_nodes_lp'(w_idx)]) begin
               w_win_v  = 1'b1;
               w_win_id = lg_nodes_lp'(w_idx);
            end
         end
      end
   end

   assign w_load = w_win_v & w_space & ~reset_i;

   // one-hot yumi to the winner, only when the word is actually taken
   always_comb begin
      node_yumi_o = '0;
      for (int k = 0; k < nodes_p; k++) begin
         node_yumi_o[k] = w_load && (w_win_id == lg_nodes_lp'(k));
      end
   end

   // output stage next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: begin
            if (w_load) begin
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (!w_load && ready_i) begin
               w_state_nxt = EMPTY;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // output stage state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // output word and source id capture; held while downstream stalls
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_data     <= '0;
         r_grant_id <= '0;
      end else if (w_load) begin
         r_data     <= node_data_i[w_win_id];
         r_grant_id <= w_win_id;
      end
   end

   // last-grant pointer and saturating burst counter, touched only on a grant
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_last      <= last_rst_lp;
         r_burst_cnt <= '0;
      end else if (w_load) begin
         r_last <= w_win_id;
         if (w_win_id == r_last) begin
            if (r_burst_cnt != burst_max_lp) begin
               r_burst_cnt <= r_burst_cnt + 1'b1;
            end
         end else begin
            r_burst_cnt <= lg_burst_lp'(1);
         end
      end
   end

   assign v_o        = (r_state == FULL);
   assign data_o     = r_data;
   assign grant_id_o = r_grant_id;

endmodule
